// File: rtl/lsu_ctrl.sv
//------------------------------------------------------------------------------
// Module      : lsu_ctrl
// Description : Load/store control stage. Accepts one EXU memory request,
//               checks opcode legality, alignment and the RAM window, and
//               drives the data memory port for a single cycle. Load data is
//               sign- or zero-extended, and the result goes back to WBU as a
//               registered response. Only one request is outstanding at a time.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef WdtTypeCnt
`define WdtTypeCnt 2
`endif
`ifndef Wdt8
`define Wdt8  2'd0
`endif
`ifndef Wdt16
`define Wdt16 2'd1
`endif
`ifndef Wdt32
`define Wdt32 2'd2
`endif
`ifndef Wdt64
`define Wdt64 2'd3
`endif

module lsu_ctrl #(
   parameter int                ADDR_W   = 64,
   parameter int                DATA_W   = 64,
   parameter logic [ADDR_W-1:0] RAM_BASE = 64'h8000_0000,
   parameter logic [ADDR_W-1:0] RAM_SIZE = 64'h0800_0000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [DATA_W-1:0]      req_wdata,
   input  logic                   req_wen,
   input  logic                   req_ren,
   input  logic [`WdtTypeCnt-1:0] req_wdt,
   input  logic                   req_sext,
   input  logic [4:0]             req_rd,
   output logic [ADDR_W-1:0]      mem_raddr,
   output logic [ADDR_W-1:0]      mem_waddr,
   output logic [DATA_W-1:0]      mem_wdata,
   output logic                   mem_wen,
   output logic                   mem_ren,
   output logic [`WdtTypeCnt-1:0] wdt_op,
   input  logic [DATA_W-1:0]      mem_rdata,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [DATA_W-1:0]      resp_data,
   output logic [4:0]             resp_rd,
   output logic [1:0]             resp_fault
);

   // The window bounds use one extra bit so that an access running past 2^ADDR_W
   // does not wrap back into the window.
   localparam logic [ADDR_W:0] c_win_lo = {1'b0, RAM_BASE};
   localparam logic [ADDR_W:0] c_win_hi = {1'b0, RAM_BASE} + {1'b0, RAM_SIZE};

   localparam logic [1:0] c_fault_none  = 2'd0;
   localparam logic [1:0] c_fault_align = 2'd1;
   localparam logic [1:0] c_fault_win   = 2'd2;
   localparam logic [1:0] c_fault_ill   = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACCESS  = 2'd1,
      S_CAPTURE = 2'd2,
      S_RESP    = 2'd3
   } state_t;

   state_t                   r_state;
   logic [ADDR_W-1:0]        r_addr;
   logic [DATA_W-1:0]        r_wdata;
   logic                     r_wen;
   logic                     r_ren;
   logic [`WdtTypeCnt-1:0]   r_wdt;
   logic                     r_sext;
   logic [4:0]               r_rd;

   logic [ADDR_W:0]          w_bytes;
   logic [ADDR_W:0]          w_last;
   logic                     w_misalign;
   logic                     w_out_win;
   logic [1:0]               w_fault;
   logic [DATA_W-1:0]        w_load_data;

   // Legality checks on the incoming request, in priority order: illegal opcode, then alignment, then window.
   always_comb begin
      w_bytes    = '0;
      w_misalign = 1'b0;
      case (req_wdt)
         `Wdt8  : begin w_bytes = (ADDR_W+1)'(1); w_misalign = 1'b0;               end
         `Wdt16 : begin w_bytes = (ADDR_W+1)'(2); w_misalign = req_addr[0];         end
         `Wdt32 : begin w_bytes = (ADDR_W+1)'(4); w_misalign = |req_addr[1:0];      end
         default: begin w_bytes = (ADDR_W+1)'(8); w_misalign = |req_addr[2:0];      end
      endcase
      w_last    = {1'b0, req_addr} + w_bytes - (ADDR_W+1)'(1);
      w_out_win = ({1'b0, req_addr} < c_win_lo) || (w_last >= c_win_hi);
      if (req_wen == req_ren)
         w_fault = c_fault_ill;
      else if (w_misalign)
         w_fault = c_fault_align;
      else if (w_out_win)
         w_fault = c_fault_win;
      else
         w_fault = c_fault_none;
   end

   // Sign extension of the lane-selected read data. The memory block already zero-extends it.
   always_comb begin
      w_load_data = mem_rdata;
      if (r_sext) begin
         case (r_wdt)
            `Wdt8  : w_load_data = {{(DATA_W-8){mem_rdata[7]}},   mem_rdata[7:0]};
            `Wdt16 : w_load_data = {{(DATA_W-16){mem_rdata[15]}}, mem_rdata[15:0]};
            `Wdt32 : w_load_data = {{(DATA_W-32){mem_rdata[31]}}, mem_rdata[31:0]};
            default: w_load_data = mem_rdata;
         endcase
      end
   end

   // Request/response sequencing: IDLE -> (ACCESS -> (CAPTURE ->)) RESP -> IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_wen      <= 1'b0;
         r_ren      <= 1'b0;
         r_wdt      <= '0;
         r_sext     <= 1'b0;
         r_rd       <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_rd    <= '0;
         resp_fault <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
                  r_wen   <= req_wen;
                  r_ren   <= req_ren;
                  r_wdt   <= req_wdt;
                  r_sext  <= req_sext;
                  r_rd    <= req_rd;
                  if (w_fault != c_fault_none) begin
                     // Faults skip the memory entirely and report the offending address.
                     resp_valid <= 1'b1;
                     resp_fault <= w_fault;
                     resp_data  <= DATA_W'(req_addr);
                     resp_rd    <= req_rd;
                     r_state    <= S_RESP;
                  end else begin
                     r_state    <= S_ACCESS;
                  end
               end
            end
            S_ACCESS: begin
               if (r_ren) begin
                  r_state <= S_CAPTURE;
               end else begin
                  resp_valid <= 1'b1;
                  resp_fault <= c_fault_none;
                  resp_data  <= '0;
                  resp_rd    <= r_rd;
                  r_state    <= S_RESP;
               end
            end
            S_CAPTURE: begin
               resp_valid <= 1'b1;
               resp_fault <= c_fault_none;
               resp_data  <= w_load_data;
               resp_rd    <= r_rd;
               r_state    <= S_RESP;
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Memory strobes last only for the ACCESS cycle and are also gated by reset so that an abort never writes.
   always_comb begin
      req_ready = (r_state == S_IDLE);
      mem_wen   = rst_n && (r_state == S_ACCESS) && r_wen;
      mem_ren   = rst_n && (r_state == S_ACCESS) && r_ren;
      mem_raddr = r_addr;
      mem_waddr = r_addr;
      mem_wdata = r_wdata;
      wdt_op    = r_wdt;
   end

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_lsu_ctrl
// Description : Self-checking bench for lsu_ctrl with directed and random
//               requests checked against a behavioural reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef WdtTypeCnt
`define WdtTypeCnt 2
`endif
`ifndef Wdt8
`define Wdt8  2'd0
`endif
`ifndef Wdt16
`define Wdt16 2'd1
`endif
`ifndef Wdt32
`define Wdt32 2'd2
`endif
`ifndef Wdt64
`define Wdt64 2'd3
`endif

module tb_lsu_ctrl;

   localparam logic [63:0] c_base = 64'h8000_0000;
   localparam logic [63:0] c_size = 64'h0800_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        req_wen;
   logic        req_ren;
   logic [1:0]  req_wdt;
   logic        req_sext;
   logic [4:0]  req_rd;
   logic [63:0] mem_raddr;
   logic [63:0] mem_waddr;
   logic [63:0] mem_wdata;
   logic        mem_wen;
   logic        mem_ren;
   logic [1:0]  wdt_op;
   logic [63:0] mem_rdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_data;
   logic [4:0]  resp_rd;
   logic [1:0]  resp_fault;

   int n_checks = 0;
   int n_errors = 0;

   lsu_ctrl #(
      .ADDR_W   (64),
      .DATA_W   (64),
      .RAM_BASE (c_base),
      .RAM_SIZE (c_size)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_wen    (req_wen),
      .req_ren    (req_ren),
      .req_wdt    (req_wdt),
      .req_sext   (req_sext),
      .req_rd     (req_rd),
      .mem_raddr  (mem_raddr),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .mem_wen    (mem_wen),
      .mem_ren    (mem_ren),
      .wdt_op     (wdt_op),
      .mem_rdata  (mem_rdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_rd    (resp_rd),
      .resp_fault (resp_fault)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] wdt);
      return 1 << wdt;
   endfunction

   function automatic logic [63:0] width_mask(input logic [1:0] wdt);
      logic [63:0] one = 64'd1;
      if (nbytes(wdt) == 8) return '1;
      return (one << (8 * nbytes(wdt))) - 64'd1;
   endfunction

   // Reference fault classification straight from the legality rules.
   function automatic logic [1:0] ref_fault(input logic [63:0] addr, input logic wen,
                                            input logic ren, input logic [1:0] wdt);
      logic [64:0] a   = {1'b0, addr};
      logic [64:0] nb  = 65'(nbytes(wdt));
      logic [64:0] lo  = {1'b0, c_base};
      logic [64:0] hi  = {1'b0, c_base} + {1'b0, c_size};
      if (wen == ren)                 return 2'd3;
      if ((a % nb) != 65'd0)          return 2'd1;
      if (a < lo || a + nb > hi)      return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic [63:0] ref_load(input logic [63:0] raw, input logic [1:0] wdt,
                                            input logic sext);
      logic [63:0] m = width_mask(wdt);
      logic [63:0] v = raw & m;
      int          top = 8 * nbytes(wdt) - 1;
      if (sext && nbytes(wdt) < 8 && v[top]) v = v | ~m;
      return v;
   endfunction

   task automatic run_txn(input logic [63:0] addr, input logic [63:0] wdata, input logic wen,
                          input logic ren, input logic [1:0] wdt, input logic sext,
                          input logic [4:0] rd, input logic [63:0] raw, input int stall);
      logic [1:0]  ef;
      logic [63:0] ed;
      int          elat;
      int          lat;
      int          nw;
      int          nr;
      int          t;
      ef   = ref_fault(addr, wen, ren, wdt);
      ed   = (ef != 2'd0) ? addr : (ren ? ref_load(raw, wdt, sext) : 64'd0);
      elat = (ef != 2'd0) ? 1 : (ren ? 3 : 2);
      t = 0;
      while (!req_ready && t < 20) begin
         @(posedge clk); #1; t++;
      end
      if (!req_ready) begin
         check_value("ready_timeout", 64'(req_ready), 64'd1);
         return;
      end
      @(negedge clk);
      req_addr  = addr;  req_wdata = wdata; req_wen = wen; req_ren = ren;
      req_wdt   = wdt;   req_sext  = sext;  req_rd  = rd;
      mem_rdata = raw & width_mask(wdt);
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = $urandom;
      lat = 1; nw = 0; nr = 0;
      forever begin
         if (mem_wen) begin
            nw++;
            check_value("waddr", mem_waddr, addr);
            check_value("wdata", mem_wdata, wdata);
            check_value("wdt_op", 64'(wdt_op), 64'(wdt));
         end
         if (mem_ren) begin
            nr++;
            check_value("raddr", mem_raddr, addr);
            check_value("rdt_op", 64'(wdt_op), 64'(wdt));
         end
         if (resp_valid || lat > 8) break;
         @(posedge clk); #1; lat++;
      end
      check_value("latency", 64'(lat), 64'(elat));
      check_value("fault", 64'(resp_fault), 64'(ef));
      check_value("data", resp_data, ed);
      check_value("rd", 64'(resp_rd), 64'(rd));
      check_value("wen_pulses", 64'(nw), (ef == 2'd0 && wen) ? 64'd1 : 64'd0);
      check_value("ren_pulses", 64'(nr), (ef == 2'd0 && ren) ? 64'd1 : 64'd0);
      check_value("ready_in_resp", 64'(req_ready), 64'd0);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check_value("stall_valid", 64'(resp_valid), 64'd1);
         check_value("stall_data", resp_data, ed);
         check_value("stall_fault", 64'(resp_fault), 64'(ef));
         check_value("stall_ready", 64'(req_ready), 64'd0);
         check_value("stall_strobe", 64'({mem_wen, mem_ren}), 64'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check_value("release_valid", 64'(resp_valid), 64'd0);
      check_value("release_ready", 64'(req_ready), 64'd1);
   endtask

   // Store aborted by reset during its ACCESS cycle must not write.
   task automatic reset_abort_store();
      @(negedge clk);
      req_addr = 64'h8000_0010; req_wdata = 64'h1234; req_wen = 1'b1; req_ren = 1'b0;
      req_wdt = `Wdt64; req_sext = 1'b0; req_rd = 5'd9; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_value("abort_pre_wen", 64'(mem_wen), 64'd1);
      rst_n = 1'b0;
      #1;
      check_value("abort_wen", 64'(mem_wen), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_value("abort_valid", 64'(resp_valid), 64'd0);
      check_value("abort_ready", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      check_value("abort_idle_wen", 64'(mem_wen), 64'd0);
   endtask

   initial begin
      logic [63:0] a;
      logic [1:0]  w;
      logic        we;
      logic        re;
      int          sel;
      rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_wen = 1'b0;
      req_ren = 1'b0; req_wdt = '0; req_sext = 1'b0; req_rd = '0; mem_rdata = '0;
      resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_value("rst_valid", 64'(resp_valid), 64'd0);
      check_value("rst_ready", 64'(req_ready), 64'd1);
      check_value("rst_data", resp_data, 64'd0);
      check_value("rst_fault", 64'(resp_fault), 64'd0);
      check_value("rst_rd", 64'(resp_rd), 64'd0);
      check_value("rst_strobe", 64'({mem_wen, mem_ren}), 64'd0);

      run_txn(64'h8000_0004, 64'd0, 1'b0, 1'b1, `Wdt32, 1'b1, 5'd3, 64'h0000_0000_8000_0001, 0);
      check_value("tp_sext32", resp_data, 64'hFFFF_FFFF_8000_0001);
      run_txn(64'h8000_0003, 64'hAB, 1'b1, 1'b0, `Wdt8, 1'b0, 5'd4, 64'd0, 0);
      run_txn(64'h8000_0004, 64'd0, 1'b0, 1'b1, `Wdt64, 1'b0, 5'd5, 64'd0, 1);
      run_txn(64'h7FFF_FFFE, 64'd0, 1'b0, 1'b1, `Wdt16, 1'b1, 5'd6, 64'd0, 0);
      run_txn(64'hFFFF_FFFF_FFFF_FFF8, 64'h55, 1'b1, 1'b0, `Wdt64, 1'b0, 5'd7, 64'd0, 0);
      run_txn(64'h8000_0000, 64'd0, 1'b1, 1'b1, `Wdt32, 1'b0, 5'd8, 64'd0, 5);
      run_txn(64'h8000_0000, 64'd0, 1'b0, 1'b0, `Wdt8, 1'b0, 5'd8, 64'd0, 0);
      run_txn(c_base + c_size - 64'd8, 64'd0, 1'b0, 1'b1, `Wdt64, 1'b0, 5'd1, 64'hDEAD_BEEF_0BAD_F00D, 0);
      run_txn(c_base + c_size, 64'd0, 1'b0, 1'b1, `Wdt8, 1'b0, 5'd2, 64'd0, 0);
      run_txn(c_base + c_size - 64'd2, 64'd0, 1'b0, 1'b1, `Wdt16, 1'b1, 5'd2, 64'h8001, 0);
      reset_abort_store();

      for (int n = 0; n < 300; n++) begin
         w   = 2'($urandom_range(0, 3));
         sel = int'($urandom_range(0, 3));
         case (sel)
            0:       a = c_base + (64'($urandom) % c_size);
            1:       a = c_base + c_size - 64'($urandom_range(0, 16));
            2:       a = c_base - 64'($urandom_range(0, 16));
            default: a = {32'($urandom), 32'($urandom)};
         endcase
         if ($urandom_range(0, 1) == 0) a = a & ~64'(nbytes(w) - 1);
         if ($urandom_range(0, 7) == 0) begin
            we = 1'($urandom_range(0, 1)); re = we;
         end else begin
            we = 1'($urandom_range(0, 1)); re = ~we;
         end
         run_txn(a, {32'($urandom), 32'($urandom)}, we, re, w, 1'($urandom_range(0, 1)),
                 5'($urandom), {32'($urandom), 32'($urandom)}, int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store control stage sitting directly upstream of the data `memory` block in the NPC RV64 core.
- Accepts one load or store request from EXU over a valid/ready handshake and checks alignment, address window and opcode legality.
- Drives the memory block's read/write port for exactly one cycle, sign- or zero-extends load data, and returns a registered response toward WBU.
- Single outstanding request; blocking.

Parameters:
- ADDR_W, 64, width of request address and memory address ports
- DATA_W, 64, width of store/load data
- RAM_BASE, 64'h8000_0000, lowest legal data address
- RAM_SIZE, 64'h0800_0000, size in bytes of the legal window [RAM_BASE, RAM_BASE+RAM_SIZE)

Ports:
- clk  in  1  core clock, all state on posedge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  EXU request valid
- req_ready  out  1  high only in IDLE
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, LSB-aligned
- req_wen  in  1  store request
- req_ren  in  1  load request
- req_wdt  in  `WdtTypeCnt`  access width, using `Wdt8/`Wdt16/`Wdt32/`Wdt64
- req_sext  in  1  load result sign-extended when 1, zero-extended when 0
- req_rd  in  5  destination register tag, echoed back
- mem_raddr  out  ADDR_W  to memory block
- mem_waddr  out  ADDR_W  to memory block
- mem_wdata  out  DATA_W  to memory block
- mem_wen  out  1  to memory block
- mem_ren  out  1  to memory block
- wdt_op  out  `WdtTypeCnt`  to memory block
- mem_rdata  in  DATA_W  zero-extended, lane-selected read data, valid the cycle after mem_ren
- resp_valid  out  1  response valid
- resp_ready  in  1  WBU accepts response
- resp_data  out  DATA_W  load result; 0 for stores; faulting address on fault
- resp_rd  out  5  echoed req_rd
- resp_fault  out  2  0 none, 1 misaligned, 2 out-of-window, 3 illegal (wen==ren)

Behaviour:
- Reset (rst_n==0 at posedge):
  - state=IDLE; resp_valid=0, resp_data=0, resp_rd=0, resp_fault=0.
  - All captured request registers cleared.
  - mem_wen and mem_ren are additionally gated combinationally by rst_n, so a reset asserted in the ACCESS cycle issues no write.
- States: IDLE, ACCESS, CAPTURE, RESP.
- IDLE:
  - req_ready=1. A handshake (req_valid && req_ready) registers addr, wdata, wen, ren, wdt, sext and rd.
  - Checks are evaluated on the request inputs in priority order: illegal (wen==ren), then misaligned, then out-of-window. For misaligned, the 16-bit case tests addr[0], 32-bit tests addr[1:0], 64-bit tests addr[2:0].
  - Any fault: go to RESP with resp_fault set, resp_data=req_addr; no memory strobe is ever issued.
  - Otherwise go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_ren or mem_wen is asserted from the registered request; wdt_op, mem_raddr/mem_waddr (both = registered addr) and mem_wdata are driven.
  - Load: go to CAPTURE. Store: go to RESP with resp_data=0, resp_fault=0.
- CAPTURE (1 cycle):
  - resp_data is registered from mem_rdata.
  - When sext=1, bit 7/15/31 is replicated upward for Wdt8/16/32. Wdt64 passes through unchanged.
  - When sext=0, data passes through unchanged.
  - Go to RESP.
- RESP:
  - resp_valid=1; resp_* held stable until resp_ready.
  - On handshake go to IDLE. A new request cannot be accepted in the same cycle; req_ready stays 0 throughout RESP.
- Outside ACCESS, mem_wen=mem_ren=0. Address and data outputs hold the registered values (not X).
- Latency from accept edge to resp_valid:
  - Load: 3 cycles.
  - Store: 2 cycles.
  - Fault: 1 cycle.
- Zero-cycle resp_ready stall: RESP lasts exactly 1 cycle.
- Window check: addr >= RAM_BASE and addr + bytes - 1 < RAM_BASE + RAM_SIZE, evaluated at width ADDR_W+1 so wrap-around at 2^64 counts as out-of-window.

Test Plan:
- Load Wdt32, sext=1, addr 0x8000_0004, mem_rdata 0x0000_0000_8000_0001 -> exactly one mem_ren pulse; resp_data 0xFFFF_FFFF_8000_0001, fault 0; resp_valid 3 cycles after accept.
- Store Wdt8, addr 0x8000_0003, wdata 0xAB -> exactly one mem_wen pulse with wdt_op=`Wdt8, mem_waddr 0x8000_0003; resp_data 0, fault 0; resp_valid 2 cycles after accept.
- Load Wdt64 at 0x8000_0004 -> no mem_ren; resp_fault 1, resp_data 0x8000_0004; resp_valid 1 cycle after accept.
- Load Wdt16 at 0x7FFF_FFFE, and store Wdt64 at 0xFFFF_FFFF_FFFF_FFF8 -> each gets resp_fault 2 with no memory strobe.
- Request with wen=ren=1 -> fault 3. resp_ready held low 5 cycles -> resp_* stable, req_ready=0 throughout; release -> back to IDLE next cycle.
- rst_n=0 during the ACCESS cycle of a store -> mem_wen=0 that cycle; next cycle IDLE with resp_valid=0 and req_ready=1.
